// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requesters plus the memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output ack0, ack1, rdata0, rdata1, busy,
               mem_access_addr, mem_write_data, mem_write_en, mem_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  ack0, ack1, rdata0, rdata1, busy,
               mem_access_addr, mem_write_data, mem_write_en, mem_read
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer for the single-ported data memory shared by
// the load/store path (port 0) and a secondary master (port 1).
module data_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    data_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_q;
    logic              winner_q;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              any_req;
    logic              pick1;
    logic              ack0;
    logic              ack1;
    logic              write_en;
    logic              read_en;
    logic              busy;

    // On a tie, last_q names the port served most recently, so the other one wins.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        pick1   = bus.req1 & (~bus.req0 | ~last_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                write_en   = cmd_we_q;
                read_en    = ~cmd_we_q;
                next_state = RESP;
            end
            RESP: begin
                ack0       = ~winner_q;
                ack1       = winner_q;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command registers hold the last granted request so the memory bus never toggles while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= 1'b1;
            winner_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                winner_q    <= pick1;
                last_q      <= pick1;
                cmd_we_q    <= pick1 ? bus.we1    : bus.we0;
                cmd_addr_q  <= pick1 ? bus.addr1  : bus.addr0;
                cmd_wdata_q <= pick1 ? bus.wdata1 : bus.wdata0;
            end
            if (state == ACCESS && !cmd_we_q) begin
                if (winner_q) begin
                    rdata1_q <= bus.mem_read_data;
                end else begin
                    rdata0_q <= bus.mem_read_data;
                end
            end
        end
    end

    assign bus.ack0            = ack0;
    assign bus.ack1            = ack1;
    assign bus.rdata0          = rdata0_q;
    assign bus.rdata1          = rdata1_q;
    assign bus.busy            = busy;
    assign bus.mem_access_addr = cmd_addr_q;
    assign bus.mem_write_data  = cmd_wdata_q;
    assign bus.mem_write_en    = write_en;
    assign bus.mem_read        = read_en;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed transaction table, multi-cycle
// corner sequences, and a randomized run against a transaction-level model.
module tb_data_mem_arbiter;
    logic clk;
    logic reset_n = 1'b1;

    data_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    data_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory behind the byte address; combinational read, clocked write.
    logic [15:0] tb_mem [0:255] = '{default: 16'h0000};
    assign bus.mem_read_data = tb_mem[bus.mem_access_addr[8:1]];
    always @(posedge clk) begin
        if (bus.mem_write_en) tb_mem[bus.mem_access_addr[8:1]] <= bus.mem_write_data;
    end

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } txn_t;

    txn_t        tbl [9];
    int          total;
    int          bad;
    logic [15:0] exp_rd [2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int p, input logic r, input logic w,
                                 input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    function automatic logic ackOf(input int p);
        return (p == 0) ? bus.ack0 : bus.ack1;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack0"}, 32'(bus.ack0), 32'd0);
        checkOutput({tag, "_ack1"}, 32'(bus.ack1), 32'd0);
        checkOutput({tag, "_rdata0"}, 32'(bus.rdata0), 32'd0);
        checkOutput({tag, "_rdata1"}, 32'(bus.rdata1), 32'd0);
        checkOutput({tag, "_mem_write_en"}, 32'(bus.mem_write_en), 32'd0);
        checkOutput({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(bus.mem_access_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_write_data), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic doReset();
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
    endtask

    // Single transaction raised in IDLE; ack must appear two edges later.
    task automatic doTxn(input int p, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp);
        int   cyc;
        int   wr_cnt;
        logic seen;
        logic other;
        cyc = 0; wr_cnt = 0; seen = 1'b0; other = 1'b0;
        applyStimulus(p, 1'b1, w, a, d);
        while (!seen && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mem_write_en) wr_cnt++;
            if (ackOf(1 - p)) other = 1'b1;
            if (ackOf(p)) seen = 1'b1;
        end
        checkOutput("txn_ack_seen", 32'(seen), 32'd1);
        checkOutput("txn_ack_latency", 32'(cyc), 32'd2);
        checkOutput("txn_other_ack", 32'(other), 32'd0);
        checkOutput("txn_write_pulses", 32'(wr_cnt), w ? 32'd1 : 32'd0);
        if (!w) exp_rd[p] = exp;
        checkOutput("txn_rdata0", 32'(bus.rdata0), 32'(exp_rd[0]));
        checkOutput("txn_rdata1", 32'(bus.rdata1), 32'(exp_rd[1]));
        applyStimulus(p, 1'b0, w, a, d);
        @(posedge clk); #1;
        checkOutput("txn_back_to_idle", 32'(bus.busy), 32'd0);
    endtask

    // Both ports write at once; the first ack must come from 'first'.
    task automatic bothRequest(input int first);
        int got;
        int first_seen;
        int cyc;
        got = 0; first_seen = -1; cyc = 0;
        applyStimulus(0, 1'b1, 1'b1, 16'h0040, 16'h0A0A);
        applyStimulus(1, 1'b1, 1'b1, 16'h0042, 16'h0B0B);
        while (got < 2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (ackOf(p)) begin
                    if (got == 0) first_seen = p;
                    got++;
                    applyStimulus(p, 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
        end
        checkOutput("tie_first_winner", 32'(first_seen), 32'(first));
        checkOutput("tie_both_served", 32'(got), 32'd2);
        @(posedge clk); #1;
    endtask

    initial begin
        int   cyc;
        int   prev;
        int   k;
        int   acks [2];
        int   order [$];
        logic ack0_seen;

        total = 0;
        bad   = 0;
        tbl[0] = '{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        tbl[1] = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[2] = '{1, 1'b1, 16'h0000, 16'h0001, 16'h0000};
        tbl[3] = '{1, 1'b1, 16'h0002, 16'h0002, 16'h0000};
        tbl[4] = '{1, 1'b1, 16'h0004, 16'h0003, 16'h0000};
        tbl[5] = '{1, 1'b1, 16'h0006, 16'h0004, 16'h0000};
        tbl[6] = '{1, 1'b1, 16'h0030, 16'h5A5A, 16'h0000};
        tbl[7] = '{0, 1'b0, 16'h0030, 16'h0000, 16'h5A5A};
        tbl[8] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);

        // Reset held with random inputs, then released with no requests.
        #2 reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            @(posedge clk); #1;
            checkAllZero("reset");
        end
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1, 1'b0, 1'b0, 16'h0, 16'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("idle_busy", 32'(bus.busy), 32'd0);
            checkOutput("idle_write_en", 32'(bus.mem_write_en), 32'd0);
            checkOutput("idle_read", 32'(bus.mem_read), 32'd0);
        end

        for (int i = 0; i < 9; i++) begin
            doTxn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
        end

        // Port 1 streams four reads with req1 held high throughout.
        k = 0; cyc = 0; prev = 0; ack0_seen = 1'b0;
        applyStimulus(1, 1'b1, 1'b0, 16'h0000, 16'h0);
        while (k < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ack0) ack0_seen = 1'b1;
            if (bus.ack1) begin
                checkOutput("b2b_rdata1", 32'(bus.rdata1), 32'(k + 1));
                checkOutput("b2b_interval", 32'(cyc - prev), (k == 0) ? 32'd2 : 32'd3);
                prev = cyc;
                k++;
                applyStimulus(1, k < 4, 1'b0, 16'(2 * k), 16'h0);
            end
        end
        checkOutput("b2b_count", 32'(k), 32'd4);
        checkOutput("b2b_no_ack0", 32'(ack0_seen), 32'd0);
        exp_rd[1] = 16'h0004;
        @(posedge clk); #1;

        // Both ports write continuously from reset: grants must alternate 0,1,0,1,0,1.
        doReset();
        acks[0] = 0; acks[1] = 0; cyc = 0; prev = 0;
        applyStimulus(0, 1'b1, 1'b1, 16'h0002, 16'h1111);
        applyStimulus(1, 1'b1, 1'b1, 16'h0004, 16'h2222);
        while (order.size() < 6 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ack0 && bus.ack1) checkOutput("sim_double_ack", 32'd1, 32'd0);
            for (int p = 0; p < 2; p++) begin
                if (ackOf(p)) begin
                    checkOutput("sim_interval", 32'(cyc - prev), (order.size() == 0) ? 32'd2 : 32'd3);
                    prev = cyc;
                    order.push_back(p);
                    acks[p]++;
                    if (acks[p] == 3) applyStimulus(p, 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
        end
        checkOutput("sim_grant_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < order.size(); i++) begin
            checkOutput("sim_grant_order", 32'(order[i]), 32'(i % 2));
        end
        @(posedge clk); #1;
        doTxn(0, 1'b0, 16'h0002, 16'h0, 16'h1111);
        doTxn(1, 1'b0, 16'h0004, 16'h0, 16'h2222);

        // Reset pulse inside the ACCESS cycle of a write.
        applyStimulus(0, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
        @(posedge clk); #1;
        checkOutput("midrst_we_before", 32'(bus.mem_write_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_we_dropped", 32'(bus.mem_write_en), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_ack0", 32'(bus.ack0), 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1 reset_n = 1'b1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("midrst_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
            checkOutput("midrst_no_write", 32'(bus.mem_write_en), 32'd0);
        end
        doTxn(0, 1'b0, 16'h0020, 16'h0, 16'h0000);

        // Ties after a single-port transaction go to the other port.
        doTxn(1, 1'b0, 16'h0000, 16'h0, 16'h0001);
        bothRequest(0);
        doTxn(0, 1'b0, 16'h0000, 16'h0, 16'h0001);
        bothRequest(1);

        // Randomized traffic against a transaction-level model.
        doReset();
        begin
            logic [15:0] mm [0:255];
            logic        r [2];
            logic        w [2];
            logic [15:0] a [2];
            logic [15:0] d [2];
            int          m_phase;
            int          m_last;
            int          m_win;
            logic        m_we;
            logic [15:0] m_addr;
            logic [15:0] m_wdata;
            for (int i = 0; i < 256; i++) mm[i] = tb_mem[i];
            for (int p = 0; p < 2; p++) begin
                r[p] = 1'b0; w[p] = 1'b0; a[p] = 16'h0; d[p] = 16'h0;
            end
            m_phase = 0; m_last = 1; m_win = 0; m_we = 1'b0; m_addr = 16'h0; m_wdata = 16'h0;
            for (int t = 0; t < 600; t++) begin
                @(posedge clk);
                if (m_phase == 0) begin
                    if (r[0] || r[1]) begin
                        m_win   = (r[0] && r[1]) ? 1 - m_last : (r[1] ? 1 : 0);
                        m_last  = m_win;
                        m_we    = w[m_win];
                        m_addr  = a[m_win];
                        m_wdata = d[m_win];
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (m_we) mm[m_addr[8:1]] = m_wdata;
                    else exp_rd[m_win] = mm[m_addr[8:1]];
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
                #1;
                checkOutput("rnd_ack0", 32'(bus.ack0), 32'(m_phase == 2 && m_win == 0));
                checkOutput("rnd_ack1", 32'(bus.ack1), 32'(m_phase == 2 && m_win == 1));
                checkOutput("rnd_busy", 32'(bus.busy), 32'(m_phase != 0));
                checkOutput("rnd_write_en", 32'(bus.mem_write_en), 32'(m_phase == 1 && m_we));
                checkOutput("rnd_read", 32'(bus.mem_read), 32'(m_phase == 1 && !m_we));
                checkOutput("rnd_addr", 32'(bus.mem_access_addr), 32'(m_addr));
                checkOutput("rnd_wdata", 32'(bus.mem_write_data), 32'(m_wdata));
                checkOutput("rnd_rdata0", 32'(bus.rdata0), 32'(exp_rd[0]));
                checkOutput("rnd_rdata1", 32'(bus.rdata1), 32'(exp_rd[1]));
                for (int p = 0; p < 2; p++) begin
                    if ((m_phase == 2 && m_win == p) || !r[p]) begin
                        if ($urandom_range(0, 99) < 55) begin
                            r[p] = 1'b1;
                            w[p] = 1'($urandom_range(0, 1));
                            a[p] = 16'($urandom_range(0, 31) * 2);
                            d[p] = 16'($urandom);
                        end else begin
                            r[p] = 1'b0;
                        end
                        applyStimulus(p, r[p], w[p], a[p], d[p]);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
